mer_ratio_calc: RTL
===================

# mer_ratio_calc

Downstream consumer of the per-cycle averaging stage: at each LFSR cycle boundary it captures the averaged decision-variable power (`map_out_pwr`) and the averaged squared error (`err_square`) and computes their ratio with a multi-cycle restoring divider. The unsigned fixed-point MER ratio it produces goes to SignalTap/ISSP probes for MER readout. It is one block per MER measurement chain and sits beside `avg_err_squared_55` in the deliverable top level.

## Interface
- `FRAC_BITS`, 14: fractional bits of `ratio`. `RW = 18 + FRAC_BITS`.
- `DEN_SHIFT`, 0: right shift applied to `err_square` at capture, to normalise the accumulation length.
- `sys_clk` in 1: system clock. One clock; all logic is on its rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `sym_clk_en` in 1: symbol-rate enable.
- `clr_acc` in 1: cycle pulse from `LFSR_22`. A start is `clr_acc & sym_clk_en`.
- `map_out_pwr` in 18: signed, signal power.
- `err_square` in 56: unsigned, error power.
- `ratio` out RW: unsigned U(18).(FRAC_BITS) quotient. Holds its value between results.
- `ratio_valid` out 1: one-cycle strobe when a new `ratio` is written.
- `busy` out 1: high while a division is in progress.
- `div_by_zero` out 1: qualifies the latest result. High when the denominator was 0.
- `missed_start` out 1: sticky. Set when a start arrives while `busy`. Cleared only by reset.

## Operation
- States are IDLE and DIV.
- **IDLE, start seen:**
  - numerator N = `{map_out_pwr[17] ? 0 : map_out_pwr, FRAC_BITS zeros}`. A negative power clamps to 0.
  - denominator D = `err_square >> DEN_SHIFT`.
  - If D == 0: skip division and write `ratio` = all ones, `div_by_zero`=1, `ratio_valid`=1. Stay in IDLE.
  - Otherwise: set `div_by_zero`=0, load the remainder register (RW+56 bits) with 0 and the quotient shift register with N, set the iteration counter to RW, and go to DIV.
- **DIV:**
  - Every `sys_clk` (not gated by `sym_clk_en`), shift {rem, quo} left by 1.
  - If rem ≥ D: rem −= D and set quo[0]=1.
  - Decrement the counter.
  - On the iteration where the counter reaches 0: write `ratio`=quo, pulse `ratio_valid`, and return to IDLE.
- **Start while in DIV:** ignored, and `missed_start` is set. Operands are never re-captured mid-division.
- **Start on the same edge the division finishes:** ignored and flagged as missed, because the block is still busy on that edge.
- **Range:** the quotient is always < 2^RW, so no overflow path exists.
- **Reset mid-operation:** aborts the division. No `ratio_valid` is produced.
- **Reset values:** state IDLE; `ratio`=0, `ratio_valid`=0, `busy`=0, `div_by_zero`=0, `missed_start`=0; counter and working registers 0.

## Timing
- Start sampled at edge T with D≠0:
  - `busy` is high from after edge T through edge T+RW.
  - The final shift happens at edge T+RW. `ratio` updates and `ratio_valid` goes high after that edge and falls at edge T+RW+1.
  - Latency is RW edges (32 for the defaults).
- Start at T with D==0: `ratio`, `div_by_zero` and `ratio_valid` are updated at edge T. `busy` never rises.
- The earliest accepted next start is at edge T+RW+1.
- Minimum cycle spacing for the defaults is 4 symbols of 4 sys_clk each, at the `clk_en` ratio. That is shorter than 32, so `missed_start` flags mis-parameterisation. Normal LFSR cycles (2^22−1 symbols) never trip it.

## Configuration
- Macro: `MER_RATIO_LOG2_EN`.
- **Defined:** adds output `ratio_log2` [7:0], registered on the same edge as `ratio`.
  - Upper 5 bits = index of the leading one of `ratio`.
  - Lower 3 bits = the 3 bits immediately below the leading one (piecewise-linear log2, zero-padded if the index is below 3).
  - `ratio`==0 gives 0. The div-by-zero result gives 0xFF. Reset value is 0.
  - Host conversion: MER dB ≈ 3.0103·(ratio_log2/8 − FRAC_BITS).
- **Undefined:** the port and its logic are absent. All other behaviour is identical.

## Test plan
- `map_out_pwr`=1000, `err_square`=10, start at T -> `ratio`=0x00190000 with `ratio_valid` high for one cycle after edge T+32, `div_by_zero`=0. With `MER_RATIO_LOG2_EN`, `ratio_log2`=0xA4.
- `err_square`=0, `map_out_pwr`=500 -> `ratio`=0xFFFFFFFF and `div_by_zero`=1 after edge T, `busy` never high.
- `map_out_pwr`=−5, `err_square`=7 -> `ratio`=0 after edge T+32.
- Start at T, second start at T+10 -> first result unaffected, `missed_start`=1 and stays 1 until `reset`.
- Reset asserted at T+10 of a division -> no `ratio_valid`, all outputs 0. A new start at T+12 completes normally at T+44.
- `clr_acc`=1 with `sym_clk_en`=0 -> no start, `busy` stays 0.

Source files
------------

// File: rtl/mer_ratio_calc.sv
// MER ratio calculator: captures averaged signal power and error power at each
// LFSR cycle start and divides them with a multi-cycle restoring divider.
// Optional macro MER_RATIO_LOG2_EN adds a piecewise-linear log2 output ratio_log2.
module mer_ratio_calc #(
  parameter int unsigned FRAC_BITS = 14,
  parameter int unsigned DEN_SHIFT = 0,
  localparam int unsigned RW       = 18 + FRAC_BITS
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          sym_clk_en,
  input  logic          clr_acc,
  input  logic [17:0]   map_out_pwr,
  input  logic [55:0]   err_square,
  output logic [RW-1:0] ratio,
  output logic          ratio_valid,
  output logic          busy,
  output logic          div_by_zero,
  output logic          missed_start
`ifdef MER_RATIO_LOG2_EN
  ,
  output logic [7:0]    ratio_log2
`endif
);

  localparam int unsigned PW   = 18;
  localparam int unsigned EW   = 56;
  localparam int unsigned REMW = RW + EW;
  localparam int unsigned CW   = $clog2(RW + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [REMW-1:0] r_rem, w_rem_nxt;
  logic [RW-1:0]   r_quo, w_quo_nxt;
  logic [EW-1:0]   r_den, w_den_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [RW-1:0]   r_ratio, w_ratio_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_dbz, w_dbz_nxt;
  logic            r_missed, w_missed_nxt;

  logic            w_start;
  logic [RW-1:0]   w_num;
  logic [EW-1:0]   w_den_in;
  logic [REMW-1:0] w_rem_sh;
  logic            w_ge;
  logic [REMW-1:0] w_rem_step;
  logic [RW-1:0]   w_quo_step;

  assign w_start  = clr_acc & sym_clk_en;
  // Negative power is meaningless here, clamp it to zero
  assign w_num    = map_out_pwr[PW-1] ? '0 : {map_out_pwr, FRAC_BITS'(0)};
  assign w_den_in = err_square >> DEN_SHIFT;

  // One restoring-division step on {rem, quo}
  assign w_rem_sh   = {r_rem[REMW-2:0], r_quo[RW-1]};
  assign w_ge       = (w_rem_sh >= {RW'(0), r_den});
  assign w_rem_step = w_ge ? (w_rem_sh - {RW'(0), r_den}) : w_rem_sh;
  assign w_quo_step = {r_quo[RW-2:0], w_ge};

`ifdef MER_RATIO_LOG2_EN
  logic [7:0] r_log2, w_log2_nxt;

  // Leading-one index in the upper 5 bits, next 3 bits below it as mantissa
  function automatic logic [7:0] f_log2(input logic [RW-1:0] x);
    logic [4:0]    idx;
    logic [RW-1:0] norm;
    idx = '0;
    for (int i = 0; i < int'(RW); i++) begin
      if (x[i]) idx = 5'(i);
    end
    norm = x << (RW - 1 - 32'(idx));
    return {idx, 3'(norm >> (RW - 4))};
  endfunction
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_den_nxt    = r_den;
    w_cnt_nxt    = r_cnt;
    w_ratio_nxt  = r_ratio;
    w_valid_nxt  = 1'b0;
    w_busy_nxt   = r_busy;
    w_dbz_nxt    = r_dbz;
    w_missed_nxt = r_missed;
`ifdef MER_RATIO_LOG2_EN
    w_log2_nxt   = r_log2;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_den_in == '0) begin
            w_ratio_nxt = '1;
            w_dbz_nxt   = 1'b1;
            w_valid_nxt = 1'b1;
`ifdef MER_RATIO_LOG2_EN
            w_log2_nxt  = 8'hFF;
`endif
          end else begin
            w_dbz_nxt   = 1'b0;
            w_rem_nxt   = '0;
            w_quo_nxt   = w_num;
            w_den_nxt   = w_den_in;
            w_cnt_nxt   = CW'(RW);
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_DIV;
          end
        end
      end
      S_DIV: begin
        // Operands stay frozen; a start here means the cycle is too short
        if (w_start) w_missed_nxt = 1'b1;
        w_rem_nxt = w_rem_step;
        w_quo_nxt = w_quo_step;
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_ratio_nxt = w_quo_step;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
`ifdef MER_RATIO_LOG2_EN
          w_log2_nxt  = f_log2(w_quo_step);
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_quo    <= '0;
      r_den    <= '0;
      r_cnt    <= '0;
      r_ratio  <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_dbz    <= 1'b0;
      r_missed <= 1'b0;
`ifdef MER_RATIO_LOG2_EN
      r_log2   <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_den    <= w_den_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ratio  <= w_ratio_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
      r_dbz    <= w_dbz_nxt;
      r_missed <= w_missed_nxt;
`ifdef MER_RATIO_LOG2_EN
      r_log2   <= w_log2_nxt;
`endif
    end
  end

  assign ratio        = r_ratio;
  assign ratio_valid  = r_valid;
  assign busy         = r_busy;
  assign div_by_zero  = r_dbz;
  assign missed_start = r_missed;
`ifdef MER_RATIO_LOG2_EN
  assign ratio_log2   = r_log2;
`endif

endmodule
